// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS32 control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives registered datapath strobes, waits on a variable-latency memory and traps bad opcodes.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_branch_beq,
    output logic             o_branch_bne,
    output logic             o_iord,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_reg_write,
    output logic [1:0]       o_reg_dst,
    output logic [1:0]       o_memto_reg,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_pc_src,
    output logic [3:0]       o_state,
    output logic             o_illegal,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_retired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_EXEC_I = 4'd10, S_IWB    = 4'd11,
        S_JAL    = 4'd12, S_HALT   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       beq;
        logic       bne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] memto_reg;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_read = 1'b1; c.src_b = 2'b01; end
            S_DECODE: c.src_b = 2'b11;
            S_EXEC_R: begin c.src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
            S_EXEC_I: begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu_op = 2'b11; end
            S_IWB:    c.reg_write = 1'b1;
            S_MEMADR: begin c.src_a = 1'b1; c.src_b = 2'b10; end
            S_MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.memto_reg = 2'b01; end
            S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
            S_BRANCH: begin
                c.src_a  = 1'b1;
                c.alu_op = 2'b01;
                c.pc_src = 2'b01;
                c.beq    = (op == 6'b000100);
                c.bne    = (op == 6'b000101);
            end
            S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            S_JAL:    begin
                c.pc_src    = 2'b10;
                c.pc_write  = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b10;
                c.memto_reg = 2'b10;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t          state, nxt;
    ctrl_t           ctrl;
    logic [TW-1:0]   wait_cnt;
    logic            waiting, expired, retire;

    // Waiting is keyed off the registered request so the idle cycle right after reset
    // neither consumes a ready nor counts toward the timeout.
    always_comb begin
        waiting = ctrl.mem_read | ctrl.mem_write;
        expired = waiting & ~i_mem_ready & (wait_cnt == TW'(MEM_TIMEOUT - 1));
        nxt     = state;
        retire  = 1'b0;
        case (state)
            S_FETCH: begin
                if (waiting && i_mem_ready) nxt = S_DECODE;
                else if (expired)           nxt = S_HALT;
            end
            S_DECODE: begin
                case (i_opcode)
                    6'b000000:                        nxt = S_EXEC_R;
                    6'b100011, 6'b101011:             nxt = S_MEMADR;
                    6'b000100, 6'b000101:             nxt = S_BRANCH;
                    6'b000010:                        nxt = S_JUMP;
                    6'b000011:                        nxt = S_JAL;
                    6'b001000, 6'b001010, 6'b001011, 6'b001100,
                    6'b001101, 6'b001110, 6'b001111:  nxt = S_EXEC_I;
                    default:                          nxt = S_HALT;
                endcase
            end
            S_EXEC_R: nxt = S_ALUWB;
            S_EXEC_I: nxt = S_IWB;
            S_MEMADR: nxt = (i_opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (i_mem_ready)  nxt = S_MEMWB;
                else if (expired) nxt = S_HALT;
            end
            S_MEMWR: begin
                if (i_mem_ready) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end else if (expired) begin
                    nxt = S_HALT;
                end
            end
            S_ALUWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP, S_JAL: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default: nxt = S_HALT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_FETCH;
            ctrl      <= '0;
            wait_cnt  <= '0;
            o_illegal <= 1'b0;
            o_mem_err <= 1'b0;
            o_retired <= '0;
        end else begin
            state <= nxt;
            ctrl  <= decode(nxt, i_opcode);
            if (nxt != state)                wait_cnt <= '0;
            else if (waiting && !i_mem_ready) wait_cnt <= wait_cnt + TW'(1);
            if (expired)                          o_mem_err <= 1'b1;
            if (state == S_DECODE && nxt == S_HALT) o_illegal <= 1'b1;
            if (retire)                           o_retired <= o_retired + CNT_W'(1);
        end
    end

    // IR latch and PC+4 follow the fetch ready in the same cycle.
    assign o_ir_write   = ctrl.mem_read & ~ctrl.iord & i_mem_ready;
    assign o_pc_write   = ctrl.pc_write | o_ir_write;
    assign o_branch_beq = ctrl.beq;
    assign o_branch_bne = ctrl.bne;
    assign o_iord       = ctrl.iord;
    assign o_mem_read   = ctrl.mem_read;
    assign o_mem_write  = ctrl.mem_write;
    assign o_reg_write  = ctrl.reg_write;
    assign o_reg_dst    = ctrl.reg_dst;
    assign o_memto_reg  = ctrl.memto_reg;
    assign o_alu_src_a  = ctrl.src_a;
    assign o_alu_src_b  = ctrl.src_b;
    assign o_alu_op     = ctrl.alu_op;
    assign o_pc_src     = ctrl.pc_src;
    assign o_state      = state;

endmodule
